// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: shares one 64-bit RV64I/M ALU between NUM_REQ requesters.
// Round-robin arbitration in IDLE picks one request. Its op, operands, tag and
// requester id are captured and held on the ALU inputs for the op's latency
// class (simple = 1, mul = MUL_LAT, div = DIV_LAT cycles). The ALU result is then
// returned over a valid/ready port. At most one op is in flight.
//
// Ports:
//   clk_i, reset_i (sync, active high), flush_i (squash in-flight op)
//   req_valid_i / req_ready_o            per-requester handshake
//   req_op_i, req_usign_i, req_lat_class_i, req_src_a_i, req_src_b_i, req_tag_i
//                                        packed per-requester op fields
//   alu_op_o, alu_usign_o, alu_src_a_o, alu_src_b_o   held ALU inputs
//   alu_result_i, alu_take_branch_i                   ALU outputs
//   out_valid_o / out_ready_i, out_result_o, out_take_branch_o, out_tag_o,
//   out_req_id_o                                      completion port
//
// Optional build macro ALU_SEQ_PERF_EN adds perf_busy_cycles_o, perf_grants_o
// and perf_stall_cycles_o (32-bit wrapping counters, cleared only by reset).
module alu_issue_sequencer #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8,
  localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*OP_W-1:0]  req_op_i,
  input  logic [NUM_REQ-1:0]       req_usign_i,
  input  logic [NUM_REQ*2-1:0]     req_lat_class_i,
  input  logic [NUM_REQ*64-1:0]    req_src_a_i,
  input  logic [NUM_REQ*64-1:0]    req_src_b_i,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
  output logic [OP_W-1:0]          alu_op_o,
  output logic                     alu_usign_o,
  output logic [63:0]              alu_src_a_o,
  output logic [63:0]              alu_src_b_o,
  input  logic [63:0]              alu_result_i,
  input  logic                     alu_take_branch_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [63:0]              out_result_o,
  output logic                     out_take_branch_o,
  output logic [TAG_W-1:0]         out_tag_o,
  output logic [IdW-1:0]           out_req_id_o
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_busy_cycles_o,
  output logic [31:0]              perf_grants_o,
  output logic [31:0]              perf_stall_cycles_o
`endif
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Counter preload is lat-1 so the result is latched on the lat-th BUSY cycle.
  localparam logic [7:0] MulCnt = 8'(MUL_LAT - 1);
  localparam logic [7:0] DivCnt = 8'(DIV_LAT - 1);

  state_e               state_q, state_d;
  logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic                 usign_q, usign_d;
  logic [63:0]          src_a_q, src_a_d;
  logic [63:0]          src_b_q, src_b_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [IdW-1:0]       id_q, id_d;
  logic                 out_valid_q, out_valid_d;
  logic [63:0]          out_result_q, out_result_d;
  logic                 out_take_branch_q, out_take_branch_d;

  logic                 grant_valid;
  logic [IdW-1:0]       grant_idx;
  logic                 accept;
  int unsigned          idx;

  // Unpack the flat request buses so the granted entry can be picked by index.
  logic [OP_W-1:0]      op_arr    [NUM_REQ];
  logic [1:0]           cls_arr   [NUM_REQ];
  logic [63:0]          src_a_arr [NUM_REQ];
  logic [63:0]          src_b_arr [NUM_REQ];
  logic [TAG_W-1:0]     tag_arr   [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g]    = req_op_i[g*OP_W +: OP_W];
    assign cls_arr[g]   = req_lat_class_i[g*2 +: 2];
    assign src_a_arr[g] = req_src_a_i[g*64 +: 64];
    assign src_b_arr[g] = req_src_b_i[g*64 +: 64];
    assign tag_arr[g]   = req_tag_i[g*TAG_W +: TAG_W];
  end

  // First valid requester at or after rr_ptr, with wrap.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_valid && req_valid_i[IdW'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = IdW'(idx);
      end
    end
  end

  assign accept = (state_q == StIdle) && grant_valid && !flush_i && !reset_i;

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    cnt_d             = cnt_q;
    op_d              = op_q;
    usign_d           = usign_q;
    src_a_d           = src_a_q;
    src_b_d           = src_b_q;
    tag_d             = tag_q;
    id_d              = id_q;
    out_valid_d       = out_valid_q;
    out_result_d      = out_result_q;
    out_take_branch_d = out_take_branch_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = op_arr[grant_idx];
          usign_d = req_usign_i[grant_idx];
          src_a_d = src_a_arr[grant_idx];
          src_b_d = src_b_arr[grant_idx];
          tag_d   = tag_arr[grant_idx];
          id_d    = grant_idx;
          case (cls_arr[grant_idx])
            2'd1:    cnt_d = MulCnt;
            2'd2:    cnt_d = DivCnt;
            default: cnt_d = '0;
          endcase
          rr_ptr_d = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          out_result_d      = alu_result_i;
          out_take_branch_d = alu_take_branch_i;
          out_valid_d       = 1'b1;
          state_d           = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush wins over everything; a same-cycle output handshake still counts
    // as consumed because out_valid drops either way.
    if (flush_i) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q           <= StIdle;
      rr_ptr_q          <= '0;
      cnt_q             <= '0;
      op_q              <= '0;
      usign_q           <= 1'b0;
      src_a_q           <= '0;
      src_b_q           <= '0;
      tag_q             <= '0;
      id_q              <= '0;
      out_valid_q       <= 1'b0;
      out_result_q      <= '0;
      out_take_branch_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      cnt_q             <= cnt_d;
      op_q              <= op_d;
      usign_q           <= usign_d;
      src_a_q           <= src_a_d;
      src_b_q           <= src_b_d;
      tag_q             <= tag_d;
      id_q              <= id_d;
      out_valid_q       <= out_valid_d;
      out_result_q      <= out_result_d;
      out_take_branch_q <= out_take_branch_d;
    end
  end

  assign alu_op_o          = op_q;
  assign alu_usign_o       = usign_q;
  assign alu_src_a_o       = src_a_q;
  assign alu_src_b_o       = src_b_q;
  assign out_valid_o       = out_valid_q;
  assign out_result_o      = out_result_q;
  assign out_take_branch_o = out_take_branch_q;
  assign out_tag_o         = tag_q;
  assign out_req_id_o      = id_q;

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_grants_q, perf_stall_q;

  // Deliberately not cleared by flush.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_busy_q   <= '0;
      perf_grants_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (state_q != StIdle)                 perf_busy_q   <= perf_busy_q + 32'd1;
      if (accept)                            perf_grants_q <= perf_grants_q + 32'd1;
      if (state_q == StDone && !out_ready_i) perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_busy_cycles_o  = perf_busy_q;
  assign perf_grants_o       = perf_grants_q;
  assign perf_stall_cycles_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Self-checking bench for alu_issue_sequencer (NUM_REQ=2, MUL_LAT=3, DIV_LAT=8).
// A small behavioural ALU sits on the ALU port; expected values are hand-computed.
module tb_alu_issue_sequencer;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned TAG_W   = 6;
  localparam logic [5:0]  OpAdd = 6'd0, OpSub = 6'd1, OpMul = 6'd2, OpDiv = 6'd3, OpBeq = 6'd4;

  logic              clk = 1'b0;
  logic              reset, flush;
  logic [1:0]        req_valid, req_ready, req_usign;
  logic [11:0]       req_op, req_tag;
  logic [3:0]        req_lat_class;
  logic [127:0]      req_src_a, req_src_b;
  logic [5:0]        alu_op;
  logic              alu_usign;
  logic [63:0]       alu_src_a, alu_src_b, alu_result;
  logic              alu_take_branch;
  logic              out_valid, out_ready, out_take_branch;
  logic [63:0]       out_result;
  logic [5:0]        out_tag;
  logic              out_req_id;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0]       perf_busy, perf_grants, perf_stall;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_issue_sequencer #(
    .NUM_REQ(NUM_REQ), .OP_W(OP_W), .TAG_W(TAG_W), .MUL_LAT(3), .DIV_LAT(8)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .flush_i          (flush),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_op_i         (req_op),
    .req_usign_i      (req_usign),
    .req_lat_class_i  (req_lat_class),
    .req_src_a_i      (req_src_a),
    .req_src_b_i      (req_src_b),
    .req_tag_i        (req_tag),
    .alu_op_o         (alu_op),
    .alu_usign_o      (alu_usign),
    .alu_src_a_o      (alu_src_a),
    .alu_src_b_o      (alu_src_b),
    .alu_result_i     (alu_result),
    .alu_take_branch_i(alu_take_branch),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_result_o     (out_result),
    .out_take_branch_o(out_take_branch),
    .out_tag_o        (out_tag),
    .out_req_id_o     (out_req_id)
`ifdef ALU_SEQ_PERF_EN
    ,
    .perf_busy_cycles_o (perf_busy),
    .perf_grants_o      (perf_grants),
    .perf_stall_cycles_o(perf_stall)
`endif
  );

  // Behavioural stand-in for the shared ALU.
  always_comb begin
    alu_result      = '0;
    alu_take_branch = 1'b0;
    case (alu_op)
      OpAdd: alu_result = alu_src_a + alu_src_b;
      OpSub: alu_result = alu_src_a - alu_src_b;
      OpMul: alu_result = alu_src_a * alu_src_b;
      OpDiv: alu_result = (alu_src_b == 64'd0) ? '1 : alu_src_a / alu_src_b;
      OpBeq: alu_take_branch = (alu_src_a == alu_src_b);
      default: ;
    endcase
  end

  typedef struct {
    logic        req;
    logic [1:0]  cls;
    logic [5:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  tag;
    logic [63:0] exp_res;
    logic        exp_br;
    int          lat;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic r, input logic [1:0] cls, input logic [5:0] op,
                         input logic [63:0] a, input logic [63:0] b, input logic [5:0] tag);
    if (r) begin
      req_lat_class[3:2] = cls; req_op[11:6] = op; req_usign[1] = 1'b0;
      req_src_a[127:64] = a; req_src_b[127:64] = b; req_tag[11:6] = tag;
    end else begin
      req_lat_class[1:0] = cls; req_op[5:0] = op; req_usign[0] = 1'b0;
      req_src_a[63:0] = a; req_src_b[63:0] = b; req_tag[5:0] = tag;
    end
  endtask

  task automatic wait_grant(input logic r, output bit got);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
    end
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1; flush = 1'b0; req_valid = 2'b00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_op(input string name, input vec_t v);
    bit got;
    bit moved;
    int m;
    @(posedge clk); #1;
    set_req(v.req, v.cls, v.op, v.a, v.b, v.tag);
    req_valid[v.req] = 1'b1;
    out_ready = 1'b1;
    wait_grant(v.req, got);
    check({name, "_grant"}, 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid[v.req] = 1'b0;
    moved = 1'b0; m = 0; got = 1'b0;
    for (int i = 1; i <= v.lat + 4 && !got; i++) begin
      @(negedge clk);
      if (alu_src_a !== v.a || alu_src_b !== v.b) moved = 1'b1;
      if (out_valid) begin got = 1'b1; m = i; end
    end
    check({name, "_latency"}, 64'(m), 64'(v.lat + 1));
    check({name, "_result"}, out_result, v.exp_res);
    check({name, "_branch"}, 64'(out_take_branch), 64'(v.exp_br));
    check({name, "_tag"}, 64'(out_tag), 64'(v.tag));
    check({name, "_id"}, 64'(out_req_id), 64'(v.req));
    check({name, "_src_moved"}, 64'(moved), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check({name, "_valid_clear"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         got;
    bit         bad;
    int         n;
    logic [7:0] grs;

    reset = 1'b1; flush = 1'b0; req_valid = 2'b00; out_ready = 1'b1;
    req_usign = '0; req_op = '0; req_tag = '0; req_lat_class = '0;
    req_src_a = '0; req_src_b = '0;

    vecs[0] = '{1'b0, 2'd0, OpAdd, 64'd5, 64'd7, 6'd3, 64'd12, 1'b0, 1};
    vecs[1] = '{1'b1, 2'd0, OpSub, 64'd10, 64'd3, 6'd9, 64'd7, 1'b0, 1};
    vecs[2] = '{1'b0, 2'd1, OpMul, 64'd6, 64'd7, 6'd5, 64'd42, 1'b0, 3};
    vecs[3] = '{1'b1, 2'd2, OpDiv, 64'd100, 64'd7, 6'd12, 64'd14, 1'b0, 8};
    vecs[4] = '{1'b0, 2'd2, OpDiv, 64'd5, 64'd0, 6'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8};
    vecs[5] = '{1'b1, 2'd3, OpBeq, 64'd4, 64'd4, 6'd63, 64'd0, 1'b1, 1};
    vecs[6] = '{1'b0, 2'd0, OpAdd, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd2, 64'd0, 1'b0, 1};

    // Reset state, with requests pending to show req_ready stays low.
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", out_result, 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    check("rst_id", 64'(out_req_id), 64'd0);
    check("rst_src_a", alu_src_a, 64'd0);
    req_valid = 2'b00;
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 7; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Round robin: both requesters always valid.
    reset_dut();
    set_req(1'b0, 2'd0, OpAdd, 64'd1, 64'd1, 6'd1);
    set_req(1'b1, 2'd0, OpAdd, 64'd2, 64'd2, 6'd2);
    req_valid = 2'b11;
    n = 0; grs = '0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        grs = {grs[5:0], req_ready};
        n++;
      end
    end
    check("rr_count", 64'(n), 64'd4);
    check("rr_order", 64'(grs), 64'h66);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);

    // Backpressure in DONE with a competing request pending.
    #1;
    set_req(1'b0, 2'd0, OpAdd, 64'd1, 64'd2, 6'd7);
    out_ready = 1'b0;
    req_valid = 2'b01;
    wait_grant(1'b0, got);
    check("bp_grant", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b10;
    set_req(1'b1, 2'd0, OpAdd, 64'd10, 64'd20, 6'd8);
    wait_valid(got);
    check("bp_valid", 64'(got), 64'd1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (out_valid !== 1'b1 || out_result !== 64'd3 || out_tag !== 6'd7 || req_ready !== 2'b00)
        bad = 1'b1;
    end
    check("bp_hold", 64'(bad), 64'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_valid_drop", 64'(out_valid), 64'd0);
    check("bp_next_grant", 64'(req_ready), 64'b10);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_valid(got);
    check("bp_second_result", out_result, 64'd30);
    check("bp_second_id", 64'(out_req_id), 64'd1);

    // Flush during a DIV at cnt=4 with requester 1 waiting.
    reset_dut();
    set_req(1'b0, 2'd2, OpDiv, 64'd100, 64'd7, 6'd20);
    req_valid = 2'b01;
    wait_grant(1'b0, got);
    check("fl_grant", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b10;
    set_req(1'b1, 2'd0, OpAdd, 64'd2, 64'd3, 6'd4);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("fl_no_accept", 64'(req_ready), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_regrant", 64'(req_ready), 64'b10);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_valid(got);
    check("fl_result", out_result, 64'd5);
    check("fl_tag", 64'(out_tag), 64'd4);

    // Reset in the middle of a DIV: rr_ptr returns to 0.
    @(posedge clk); #1;
    set_req(1'b0, 2'd2, OpDiv, 64'd81, 64'd9, 6'd11);
    req_valid = 2'b01;
    wait_grant(1'b0, got);
    @(posedge clk); #1;
    req_valid = 2'b11;
    set_req(1'b1, 2'd0, OpAdd, 64'd1, 64'd1, 6'd6);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rm_ready_in_reset", 64'(req_ready), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rm_valid", 64'(out_valid), 64'd0);
    check("rm_result", out_result, 64'd0);
    check("rm_src_a", alu_src_a, 64'd0);
    check("rm_grant_ptr0", 64'(req_ready), 64'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (12) @(posedge clk);

`ifdef ALU_SEQ_PERF_EN
    reset_dut();
    @(negedge clk);
    check("perf_reset", 64'({perf_busy, perf_grants}) | 64'(perf_stall), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_req(1'b0, 2'd1, OpMul, 64'd6, 64'd7, 6'd1);
    req_valid = 2'b01;
    wait_grant(1'b0, got);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_valid(got);
    @(posedge clk); #1;
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("perf_grants", 64'(perf_grants), 64'd1);
    check("perf_busy", 64'(perf_busy), 64'd6);
    check("perf_stall", 64'(perf_stall), 64'd2);
    check("perf_result", out_result, 64'd42);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Shares one 64-bit integer ALU (RV64I/M op set) between NUM_REQ issue requesters using round-robin arbitration.
- Captures the granted op and its operands, then holds the ALU inputs stable for the op's latency class: simple, multiply or divide.
- Returns the result, branch decision, tag and requester id over a valid/ready output port.
- Sits between the reservation stations and the shared ALU in the execute stage.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- OP_W, 6: width of the ALU operation code.
- TAG_W, 6: width of the destination/ROB tag carried through the block.
- MUL_LAT, 3: cycles the ALU is occupied by the MUL class (1..256).
- DIV_LAT, 8: cycles the ALU is occupied by the DIV/REM class (1..256).

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- flush, in, 1: squash the in-flight op (mispredict).
- req_valid, in, NUM_REQ: per-requester request.
- req_ready, out, NUM_REQ: per-requester grant/accept.
- req_op, in, NUM_REQ*OP_W: ALU operation per requester.
- req_usign, in, NUM_REQ: unsigned-operation bit per requester.
- req_lat_class, in, NUM_REQ*2: latency class; 0 = simple, 1 = mul, 2 = div, 3 = simple.
- req_src_a, in, NUM_REQ*64: operand A.
- req_src_b, in, NUM_REQ*64: operand B.
- req_tag, in, NUM_REQ*TAG_W: tag.
- alu_op, out, OP_W: to ALU control aluop.
- alu_usign, out, 1: to ALU control usign.
- alu_src_a, out, 64: to ALU sourceA.
- alu_src_b, out, 64: to ALU sourceB.
- alu_result, in, 64: from ALU result.
- alu_take_branch, in, 1: from ALU take_branch.
- out_valid, out, 1: result available.
- out_ready, in, 1: consumer accepts the result.
- out_result, out, 64: captured result.
- out_take_branch, out, 1: captured branch decision.
- out_tag, out, TAG_W: tag of the completed op.
- out_req_id, out, clog2(NUM_REQ) (minimum 1): index of the requester that issued the completed op.

Behaviour:
- Reset: state IDLE, rr_ptr=0, cnt=0, op/operand/tag registers 0, out_valid=0, out_result=0, out_take_branch=0, out_tag=0, out_req_id=0, req_ready=0.
- ALU outputs alu_op, alu_usign, alu_src_a and alu_src_b always come straight from the captured registers and stay stable through BUSY and DONE.
- States: IDLE, BUSY, DONE.
- IDLE arbitration:
  - Grant the first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready[i]=1 combinationally for the granted i only, and only when not flush.
  - req_ready is 0 in all other states.
- On accept (req_valid[i] & req_ready[i]):
  - Capture op, usign, srcs, tag and id.
  - cnt = lat-1, where lat is 1, MUL_LAT or DIV_LAT by class.
  - rr_ptr = (i+1) mod NUM_REQ.
  - Next state BUSY.
- IDLE with no request: rr_ptr is unchanged.
- BUSY:
  - cnt!=0: cnt decrements.
  - cnt==0: latch alu_result and alu_take_branch into out_result and out_take_branch, set out_valid=1, next state DONE.
- Latency: accept at cycle T, out_valid first high at T+lat+1.
- DONE: out_valid and all out_* fields stay stable until out_ready=1. Then out_valid=0 next cycle and next state IDLE.
- Next grant is earliest one cycle after the output handshake; at most one op is in flight.
- flush has priority over everything:
  - In any state, next state IDLE, out_valid=0, cnt=0.
  - No request is accepted in the flush cycle.
  - rr_ptr is unchanged.
- flush in the same cycle as the out_ready handshake: the handshake completes and the result is considered consumed.
- reset mid-operation: same effect as flush, plus all registers go to their reset values.
- Requesters hold req_valid and fields stable until accepted; req_valid never depends on req_ready.
- Divide-by-zero and overflow are passed through from the ALU unchanged; the sequencer does not inspect results.

Optional Feature:
- Macro ALU_SEQ_PERF_EN.
- When defined, adds outputs:
  - perf_busy_cycles, out, 32: increments every cycle state!=IDLE.
  - perf_grants, out, 32: increments on every accept.
  - perf_stall_cycles, out, 32: increments every cycle in DONE with out_ready=0.
- All three reset to 0, are not cleared by flush, and wrap at 2^32.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Simple ADD: requester 0, class 0, A=5, B=7, tag 3, out_ready=1 → out_valid 2 cycles after accept, out_result=12, out_tag=3, out_req_id=0, then IDLE.
- Round robin: both requesters continuously valid with class 0 → grants alternate 0,1,0,1; rr_ptr wraps; no requester accepted twice in a row.
- Multi-cycle latency: class 1 (MUL_LAT=3) accepted at T → out_valid at T+4; class 2 (DIV_LAT=8) accepted at T → out_valid at T+9; alu_src_a and alu_src_b unchanged throughout.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_* stable, req_ready all 0; out_ready=1 → out_valid=0 next cycle, new grant the following cycle.
- Flush: flush asserted in BUSY at cnt=4 with req_valid=1 → next cycle IDLE, out_valid=0, no accept in the flush cycle, grant in the cycle after; reset asserted mid-DIV gives the same result with rr_ptr=0.
- Perf (ALU_SEQ_PERF_EN defined): one MUL op with 2 stall cycles → perf_grants=1, perf_busy_cycles=6, perf_stall_cycles=2.
